// File: rtl/autosym_sweep_ctrl.sv
// Sweeps all 2^N_IN inputs of an external function, captures its truth table and ON-set size, then checks f(x) == f(x ^ alpha).
// Done follows start by 2^N_IN*SETTLE + 2^N_IN cycles (or + j+1 on first mismatch j); AUTOSYM_TT_READBACK_EN adds tt_raddr/tt_rdata.
module autosym_sweep_ctrl #(
  parameter int N_IN   = 8,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [N_IN-1:0] alpha,
  output logic [N_IN-1:0] fn_x,
  input  logic            fn_y,
  output logic            busy,
  output logic            done,
  output logic [N_IN:0]   onset_cnt,
  output logic            symmetric,
  output logic [N_IN-1:0] mismatch_idx
`ifdef AUTOSYM_TT_READBACK_EN
  ,
  input  logic [N_IN-1:0] tt_raddr,
  output logic            tt_rdata
`endif
);

  localparam int TT_SIZE = 1 << N_IN;
  localparam int SW      = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {IDLE, SWEEP, CHECK, FIN} state_t;

  state_t            state;
  logic [N_IN-1:0]   idx;
  logic [N_IN-1:0]   alpha_q;
  logic [SW-1:0]     settle_cnt;
  logic [TT_SIZE-1:0] tt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      alpha_q      <= '0;
      settle_cnt   <= '0;
      tt           <= '0;
      fn_x         <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      onset_cnt    <= '0;
      symmetric    <= 1'b0;
      mismatch_idx <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            alpha_q      <= alpha;
            onset_cnt    <= '0;
            symmetric    <= 1'b0;
            mismatch_idx <= '0;
            busy         <= 1'b1;
            idx          <= '0;
            settle_cnt   <= '0;
            fn_x         <= '0;
            state        <= SWEEP;
          end
        end
        SWEEP: begin
          if (settle_cnt == SW'(SETTLE - 1)) begin
            tt[idx]    <= fn_y;
            onset_cnt  <= onset_cnt + {{N_IN{1'b0}}, fn_y};
            settle_cnt <= '0;
            // fn_x is left at all-ones once the sweep wraps
            if (idx == {N_IN{1'b1}}) begin
              idx   <= '0;
              state <= CHECK;
            end else begin
              idx  <= idx + N_IN'(1);
              fn_x <= idx + N_IN'(1);
            end
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end
        CHECK: begin
          if (tt[idx] != tt[idx ^ alpha_q]) begin
            mismatch_idx <= idx;
            symmetric    <= 1'b0;
            done         <= 1'b1;
            busy         <= 1'b0;
            state        <= FIN;
          end else if (idx == {N_IN{1'b1}}) begin
            mismatch_idx <= '0;
            symmetric    <= 1'b1;
            done         <= 1'b1;
            busy         <= 1'b0;
            state        <= FIN;
          end else begin
            idx <= idx + N_IN'(1);
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AUTOSYM_TT_READBACK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tt_rdata <= 1'b0;
    end else begin
      tt_rdata <= (state == IDLE) ? tt[tt_raddr] : 1'b0;
    end
  end
`endif

endmodule
